// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and
// the baud-timing helpers used by uart_rx (and uart_tx).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_rx_state_t;

  // System clocks per serial bit; truncating division, no fractional correction.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Clocks from the start-bit edge to the centre of the start bit.
  function automatic int half_bit(input int clk_hz, input int baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-byte handshake between uart_rx (master, source of bytes) and the
// consumer (slave).
//   rx_data       : FIFO head byte, 0 when nothing is buffered
//   rx_data_valid : a byte is available
//   rx_data_ready : consumer pops the head byte when valid && ready
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_ready;

  modport master (
    output rx_data,
    output rx_data_valid,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes.
// DEPTH must be a power of two and at least 2.
//   clk, reset : clock and asynchronous active-high reset
//   push, din  : write request and data; ignored when full unless popping
//   full       : no free entry
//   pop        : read request; ignored when empty
//   dout       : head entry, 0 when empty
//   empty      : no entry stored
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_en_s;
  logic             pop_en_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_en_s  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs when full.
  assign push_en_s = push && (!full || pop_en_s);
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update on accepted push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. rx_pin is synchronised, each bit is sampled at its
// centre, bytes are assembled LSB first and buffered in a FIFO presented on
// a valid/ready handshake.
//   clk, reset  : system clock and asynchronous active-high reset
//   rx_pin      : asynchronous serial input, idles high
//   rx_bus      : byte handshake (rx_data / rx_data_valid / rx_data_ready)
//   frame_error : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, good byte dropped because FIFO was full
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_CLK_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  uart_rx_if.master  rx_bus,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(UART_CLK_HZ, BAUD_RATE);
  localparam int HALF_BIT     = half_bit(UART_CLK_HZ, BAUD_RATE);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic                 sync1_r;
  logic                 rx_s;
  uart_rx_state_t       state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 frame_error_r;
  logic                 overrun_r;

  logic                 cnt_done_s;
  logic                 stop_sample_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_dout_s;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx_pin;
      rx_s    <= sync1_r;
    end
  end

  // Sample point: half a bit into START, a full bit into DATA/STOP.
  always_comb begin
    cnt_done_s = 1'b0;
    case (state_r)
      START:       cnt_done_s = (cnt_r == HALF_LAST);
      DATA, STOP:  cnt_done_s = (cnt_r == BIT_LAST);
      default:     cnt_done_s = 1'b0;
    endcase
  end

  assign stop_sample_s = (state_r == STOP) && cnt_done_s;
  assign pop_s         = rx_bus.rx_data_ready && !fifo_empty_s;
  // Good stop bit, and either a free slot or one being freed this cycle.
  assign push_s        = stop_sample_s && rx_s && (!fifo_full_s || pop_s);

  // Receive FSM with registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= WAIT_HIGH;
      cnt_r         <= CNT_ZERO;
      bit_idx_r     <= 3'd0;
      shift_r       <= {DATA_BITS{1'b0}};
      frame_error_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      frame_error_r <= 1'b0;
      overrun_r     <= 1'b0;
      case (state_r)
        // Wait for an idle line so a low line or break is not taken as a start.
        WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        IDLE: begin
          if (!rx_s) begin
            cnt_r   <= CNT_ZERO;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_done_s) begin
            if (!rx_s) begin
              cnt_r     <= CNT_ZERO;
              bit_idx_r <= 3'd0;
              state_r   <= DATA;
            end else begin
              state_r   <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_done_s) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        // Leaves at the stop-bit centre so a following start edge is caught.
        STOP: begin
          if (cnt_done_s) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              state_r <= IDLE;
              if (!push_s) begin
                overrun_r <= 1'b1;
              end
            end else begin
              frame_error_r <= 1'b1;
              state_r       <= WAIT_HIGH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= WAIT_HIGH;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (shift_r),
    .full  (fifo_full_s),
    .pop   (rx_bus.rx_data_ready),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s)
  );

  assign rx_bus.rx_data       = fifo_dout_s;
  assign rx_bus.rx_data_valid = !fifo_empty_s;
  assign frame_error          = frame_error_r;
  assign overrun              = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 10 clocks per bit, FIFO depth 4.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk;
  logic reset;
  logic rx_pin;
  logic frame_error;
  logic overrun;

  int checks;
  int failures;
  int fe_cnt;
  int ov_cnt;
  int both_cnt;

  uart_rx_if bus ();

  uart_rx #(
    .UART_CLK_HZ (1000000),
    .BAUD_RATE   (100000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_pin      (rx_pin),
    .rx_bus      (bus),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag pulse counters; tests compare deltas.
  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_error && overrun) both_cnt++;
  end

  // Drive one 8N1 frame; leaves rx_pin at stop_bit level, returns on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (10) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_pin = 1'b1;
    bus.rx_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rx_data_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.rx_data); end
    checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_flags got fe=%b ov=%b exp=0,0", frame_error, overrun); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (dut.state_r !== IDLE) begin failures++; $display("FAIL reset_to_idle got=%0d exp=%0d", dut.state_r, IDLE); end
  endtask

  task automatic test_single();
    int lat;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (bus.rx_data_valid && lat < 0) lat = i + 1;
        end
      end
    join
    checks++; if (lat < 90 || lat > 102) begin failures++; $display("FAIL single_latency got=%0d exp=90..102", lat); end
    checks++; if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== 8'hA5) begin failures++; $display("FAIL single_data got v=%b d=%h exp v=1 d=a5", bus.rx_data_valid, bus.rx_data); end
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
    checks++; if (bus.rx_data_valid !== 1'b0 || bus.rx_data !== 8'h00) begin failures++; $display("FAIL single_pop got v=%b d=%h exp v=0 d=00", bus.rx_data_valid, bus.rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    int ov0;
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL b2b_no_early_overrun got=%0d exp=0", ov_cnt - ov0); end
    send_frame(8'h05, 1'b1);
    checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== exp_b[i]) begin
        failures++; $display("FAIL b2b_drain%0d got v=%b d=%h exp v=1 d=%h", i, bus.rx_data_valid, bus.rx_data, exp_b[i]);
      end
      bus.rx_data_ready = 1'b1;
      @(negedge clk);
      bus.rx_data_ready = 1'b0;
    end
    checks++; if (bus.rx_data_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.rx_data_valid); end
  endtask

  task automatic test_frame_error();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b0);
    repeat (300) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (bus.rx_data_valid !== 1'b0 || ov_cnt - ov0 !== 0) begin failures++; $display("FAIL fe_no_push got v=%b ov=%0d exp v=0 ov=0", bus.rx_data_valid, ov_cnt - ov0); end
    send_frame(8'h3C, 1'b1);
    checks++; if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin failures++; $display("FAIL fe_recover got v=%b d=%h exp v=1 d=3c", bus.rx_data_valid, bus.rx_data); end
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (bus.rx_data_valid !== 1'b0 || fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin failures++; $display("FAIL glitch_quiet got v=%b fe=%0d ov=%0d exp 0,0,0", bus.rx_data_valid, fe_cnt - fe0, ov_cnt - ov0); end
    checks++; if (dut.state_r !== IDLE) begin failures++; $display("FAIL glitch_idle got=%0d exp=%0d", dut.state_r, IDLE); end
    send_frame(8'h81, 1'b1);
    checks++; if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== 8'h81) begin failures++; $display("FAIL glitch_next got v=%b d=%h exp v=1 d=81", bus.rx_data_valid, bus.rx_data); end
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int fe0;
    int ov0;
    send_frame(8'h11, 1'b1);
    checks++; if (bus.rx_data !== 8'h11) begin failures++; $display("FAIL mreset_preload got=%h exp=11", bus.rx_data); end
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (56) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.rx_data_valid !== 1'b0 || bus.rx_data !== 8'h00) begin failures++; $display("FAIL mreset_clear got v=%b d=%h exp v=0 d=00", bus.rx_data_valid, bus.rx_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checks++; if (bus.rx_data_valid !== 1'b0 || fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin failures++; $display("FAIL mreset_ignore got v=%b fe=%0d ov=%0d exp 0,0,0", bus.rx_data_valid, fe_cnt - fe0, ov_cnt - ov0); end
    send_frame(8'h3C, 1'b1);
    checks++; if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin failures++; $display("FAIL mreset_next got v=%b d=%h exp v=1 d=3c", bus.rx_data_valid, bus.rx_data); end
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_b [4];
    int ov0;
    bit found;
    exp_b = '{8'h02, 8'h03, 8'h04, 8'h05};
    found = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (dut.stop_sample_s) found = 1'b1;
        end
        if (found) begin
          checks++; if (bus.rx_data !== 8'h01) begin failures++; $display("FAIL full_head got=%h exp=01", bus.rx_data); end
          bus.rx_data_ready = 1'b1;
          @(negedge clk);
          bus.rx_data_ready = 1'b0;
        end
      end
    join
    checks++; if (!found) begin failures++; $display("FAIL full_timeout got=0 exp=1"); end
    checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL full_no_overrun got=%0d exp=0", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== exp_b[i]) begin
        failures++; $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, bus.rx_data_valid, bus.rx_data, exp_b[i]);
      end
      bus.rx_data_ready = 1'b1;
      @(negedge clk);
      bus.rx_data_ready = 1'b0;
    end
    checks++; if (bus.rx_data_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", bus.rx_data_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    both_cnt = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_mid_reset();
    test_full_pop_push();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL flags_exclusive got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
